// File: rtl/register_file_mp.sv
// register_file_mp
//   Parametrised register file with NUM_RD combinational read ports, optional
//   hardwired-zero register 0, optional same-cycle write-to-read bypass, a
//   per-register pending-write (busy) scoreboard and a sequential clear engine
//   that zeroes one register per cycle.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   rd_addr      packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data      packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy      scoreboard bit of each addressed register
//   wr_en/wr_addr/wr_data   writeback port, clears the busy bit
//   alloc_en/alloc_addr     marks a register pending
//   clr_req      start a full clear sweep (ignored while sweeping)
//   clr_busy     clear sweep in progress; writes and allocs are dropped
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;

  logic                wr_drop;
  logic                alloc_drop;
  logic                wr_ok;
  logic                alloc_ok;

  assign clr_busy   = (state_q == ST_CLEAR);
  assign wr_drop    = (ZERO_REG != 0) && (wr_addr == '0);
  assign alloc_drop = (ZERO_REG != 0) && (alloc_addr == '0);
  assign wr_ok      = wr_en && !wr_drop && !clr_busy;
  assign alloc_ok   = alloc_en && !alloc_drop && !clr_busy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_ok) begin
          mem_d[wr_addr]  = wr_data;
          busy_d[wr_addr] = 1'b0;
        end
        // Alloc is applied after the write so a same-register pair leaves
        // the register pending on the new producer.
        if (alloc_ok) begin
          busy_d[alloc_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          busy_d  = '0;
        end
      end
      ST_CLEAR: begin
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mem_q   <= '{default: '0};
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit;

    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    // wr_drop excludes a dropped r0 write from forwarding even with ZERO_REG.
    assign hit     = (BYPASS != 0) && wr_en && !wr_drop && (wr_addr == addr);

    assign rd_data[p*DATA_W +: DATA_W] = (clr_busy || is_zero) ? '0 :
                                         hit ? wr_data : mem_q[addr];
    assign rd_busy[p] = !(clr_busy || is_zero || hit) && busy_q[addr];
  end

endmodule
